// File: rtl/mac_scan_pkg.sv
// Shared types and constants for the mac scan-chain controller and its DFT wrapper.
package mac_scan_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    RESP    = 3'd4
  } scan_state_t;

  localparam int          MAC_CHAIN_LEN = 64;
  // x^32 + x^22 + x^2 + x + 1, feedback taps applied on shift-left
  localparam logic [31:0] MISR_POLY     = 32'h0040_0007;
  localparam logic [31:0] MISR_SEED     = 32'hFFFF_FFFF;

endpackage

// File: rtl/mac_scan_misr.sv
// 32-bit signature register compacting the unloaded scan stream (used when SCAN_MISR_EN is defined).
module mac_scan_misr
  import mac_scan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seed,
  input  logic        en,
  input  logic        bit_in,
  output logic [31:0] sig
);

  always_ff @(posedge clk) begin
    if (!rst)
      sig <= '0;
    else if (seed)
      sig <= MISR_SEED;
    else if (en)
      sig <= {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ {31'h0, bit_in};
  end

endmodule

// File: rtl/mac_scan_ctrl.sv
// Scan-chain load / capture / unload sequencer for the mac datapath.
// Optional SCAN_MISR_EN adds a 32-bit response signature on misr_sig.
module mac_scan_ctrl
  import mac_scan_pkg::*;
#(
  parameter int CHAIN_LEN = MAC_CHAIN_LEN,
  parameter int CAP_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAIN_LEN-1:0] cfg_pattern,
  input  logic [CAP_W-1:0]     cfg_cap,
  output logic                 scan_en,
  output logic                 scanin,
  input  logic                 scanout,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CHAIN_LEN-1:0] res_data
`ifdef SCAN_MISR_EN
  ,
  output logic [31:0]          misr_sig
`endif
);

  localparam int                CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CAP_W-1:0]     cap_q;
  logic [CAP_W-1:0]     cap_cnt;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] sreg;
  logic                 accept;

  assign accept    = cfg_valid && (state == IDLE);
  assign cnt_inc   = cnt + 1'b1;
  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_data  = sreg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      scan_en   <= 1'b0;
      scanin    <= 1'b0;
      res_valid <= 1'b0;
      cnt       <= '0;
      cap_cnt   <= '0;
      cap_q     <= '0;
      pat_q     <= '0;
      sreg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pat_q   <= cfg_pattern;
            cap_q   <= cfg_cap;
            sreg    <= '0;
            cnt     <= '0;
            cap_cnt <= '0;
            // bit 0 goes out in the very first LOAD cycle
            scan_en <= 1'b1;
            scanin  <= cfg_pattern[0];
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            scanin <= 1'b0;
            if (cap_q == '0) begin
              scan_en <= 1'b1;
              state   <= UNLOAD;
            end else begin
              scan_en <= 1'b0;
              state   <= CAPTURE;
            end
          end else begin
            cnt    <= cnt_inc;
            scanin <= pat_q[cnt_inc];
          end
        end
        CAPTURE: begin
          if (cap_cnt == cap_q - 1'b1) begin
            cap_cnt <= '0;
            scan_en <= 1'b1;
            state   <= UNLOAD;
          end else begin
            cap_cnt <= cap_cnt + 1'b1;
          end
        end
        UNLOAD: begin
          // first bit seen ends up in sreg[0] after CHAIN_LEN shifts
          sreg <= {scanout, sreg[CHAIN_LEN-1:1]};
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            scan_en   <= 1'b0;
            res_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          scan_en   <= 1'b0;
          scanin    <= 1'b0;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_MISR_EN
  mac_scan_misr u_misr (
    .clk    (clk),
    .rst    (rst),
    .seed   (accept),
    .en     (state == UNLOAD),
    .bit_in (scanout),
    .sig    (misr_sig)
  );
`endif

endmodule

// File: tb/tb_mac_scan_ctrl.sv
// Self-checking bench for mac_scan_ctrl with an 8-flop looped-back chain model.
module tb_mac_scan_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_pattern;
  logic [3:0]   cfg_cap;
  logic         scan_en;
  logic         scanin;
  logic         scanout;
  logic         busy;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
`ifdef SCAN_MISR_EN
  logic [31:0]  misr_sig;
`endif

  int checks   = 0;
  int failures = 0;

  mac_scan_ctrl #(.CHAIN_LEN(N), .CAP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_cap     (cfg_cap),
    .scan_en     (scan_en),
    .scanin      (scanin),
    .scanout     (scanout),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data)
`ifdef SCAN_MISR_EN
    ,
    .misr_sig    (misr_sig)
`endif
  );

  always #5 clk = ~clk;

  // Chain model: shift toward bit 0 in scan mode; optionally invert on functional edges.
  logic [N-1:0] chain = '0;
  logic         inv_mode = 1'b0;
  always @(posedge clk) begin
    if (scan_en)       chain <= {scanin, chain[N-1:1]};
    else if (inv_mode) chain <= ~chain;
  end
  assign scanout = chain[0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] misr_gold(input logic [N-1:0] bits);
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int k = 0; k < N; k++)
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ {31'h0, bits[k]};
    return s;
  endfunction

  // Latency counts rising edges from the accept edge up to the one raising res_valid.
  task automatic run_req(input string nm, input logic [N-1:0] pat, input logic [3:0] cap,
                         input logic inv, input logic [N-1:0] exp_d, input int exp_lat);
    int lat, hi, lo;
    inv_mode    = inv;
    cfg_pattern = pat;
    cfg_cap     = cap;
    res_ready   = 1'b1;
    cfg_valid   = 1'b1;
    tick();
    cfg_valid = 1'b0;
    lat = 1; hi = 0; lo = 0;
    while (!res_valid && lat < 200) begin
      if (scan_en) hi++; else lo++;
      tick();
      lat++;
    end
    chk({nm, "_lat"},    lat, exp_lat);
    chk({nm, "_en_hi"},  hi, 2 * N);
    chk({nm, "_en_lo"},  lo, int'(cap));
    chk({nm, "_data"},   res_data, exp_d);
    chk({nm, "_scanen"}, scan_en, 1'b0);
`ifdef SCAN_MISR_EN
    chk({nm, "_misr"},   misr_sig, misr_gold(exp_d));
`endif
    tick();
    chk({nm, "_rv_drop"}, res_valid, 1'b0);
    chk({nm, "_idle"},    cfg_ready, 1'b1);
  endtask

  typedef struct {
    logic [N-1:0] pat;
    logic [3:0]   cap;
    logic         inv;
    logic [N-1:0] exp_d;
    int           lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    logic seen;

    vecs[0] = '{8'hA5, 4'd0,  1'b0, 8'hA5, 17};
    vecs[1] = '{8'h3C, 4'd3,  1'b1, 8'hC3, 20};
    vecs[2] = '{8'h00, 4'd1,  1'b1, 8'hFF, 18};
    vecs[3] = '{8'h81, 4'd2,  1'b1, 8'h81, 19};
    vecs[4] = '{8'hFF, 4'd15, 1'b0, 8'hFF, 32};
    vecs[5] = '{8'h01, 4'd0,  1'b0, 8'h01, 17};

    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_cap = '0; res_ready = 1'b1;
    repeat (4) tick();
    chk("rst_scan_en",   scan_en,   1'b0);
    chk("rst_scanin",    scanin,    1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_res_data",  res_data,  8'h00);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      run_req($sformatf("vec%0d", i), vecs[i].pat, vecs[i].cap, vecs[i].inv,
              vecs[i].exp_d, vecs[i].lat);

    // Back-pressure: response held 10 cycles while new requests are ignored.
    inv_mode = 1'b0; cfg_pattern = 8'h5A; cfg_cap = 4'd0; res_ready = 1'b0; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 100) begin tick(); cyc++; end
    chk("bp_reach", res_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cfg_valid   = i[0];
      cfg_pattern = 8'h11;
      tick();
      chk("bp_hold_valid", res_valid, 1'b1);
      chk("bp_hold_data",  res_data,  8'h5A);
      chk("bp_cfg_ready",  cfg_ready, 1'b0);
    end
    cfg_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("bp_release_valid", res_valid, 1'b0);
    chk("bp_release_idle",  cfg_ready, 1'b1);
    chk("bp_release_busy",  busy,      1'b0);
    tick();
    chk("bp_no_queue", busy, 1'b0);

    // Abort: reset asserted during UNLOAD cycle 4 (after accept edge + 12 edges).
    cfg_pattern = 8'hAA; cfg_cap = 4'd0; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (12) tick();
    chk("abort_in_unload", scan_en, 1'b1);
    rst = 1'b0;
    tick();
    chk("abort_scan_en",   scan_en,  1'b0);
    chk("abort_idle",      cfg_ready, 1'b1);
    chk("abort_res_data",  res_data, 8'h00);
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin tick(); if (res_valid) seen = 1'b1; end
    chk("abort_no_resp", seen, 1'b0);
    run_req("after_abort", 8'h0F, 4'd0, 1'b0, 8'h0F, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
